// File: rtl/keypad_scanner_if.sv
// Keypad scanner port bundle: raw button lines in, debounced key events out.
interface keypad_scanner_if;
  logic [9:0] digit_i;
  logic       open_i;
  logic       close_i;
  logic       set_i;
  logic       key_valid_o;
  logic [3:0] key_code_o;
  logic       key_is_digit_o;
  logic       key_err_o;
  logic       busy_o;

  modport master (
    output digit_i, open_i, close_i, set_i,
    input  key_valid_o, key_code_o, key_is_digit_o, key_err_o, busy_o
  );

  modport slave (
    input  digit_i, open_i, close_i, set_i,
    output key_valid_o, key_code_o, key_is_digit_o, key_err_o, busy_o
  );
endinterface

// File: rtl/keypad_scanner.sv
// Synchronises, debounces and single-key-filters the 13 lock keypad buttons,
// turning each clean press into one KEY_VALID (or KEY_ERR) strobe.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.slave   kp
);

  localparam int unsigned NKEYS  = 13;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned NDIGIT = 10;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB,
    ST_HELD,
    ST_REL
  } state_e;

  state_e              state_q, state_d;
  logic [NKEYS-1:0]    sync1_q, sync2_q;
  logic [NKEYS-1:0]    sample_q, sample_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                key_valid_q, key_valid_d;
  logic                key_err_q, key_err_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                key_is_digit_q, key_is_digit_d;
  logic                busy_q, busy_d;

  logic [NKEYS-1:0]    raw_c;
  logic [NKEYS-1:0]    s_c;
  logic                one_hot_c;
  logic [CODE_W-1:0]   key_idx_c;

  // Bit position equals key code: digits 0-9, then OPEN, CLOSE, SET.
  assign raw_c     = {kp.set_i, kp.close_i, kp.open_i, kp.digit_i};
  assign s_c       = sync2_q;
  assign one_hot_c = $onehot(sample_q);

  // Encode the captured sample; only meaningful when it is one-hot.
  always_comb begin
    key_idx_c = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (sample_q[i]) begin
        key_idx_c = CODE_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sync1_q        <= '0;
      sync2_q        <= '0;
      sample_q       <= '0;
      cnt_q          <= '0;
      key_valid_q    <= 1'b0;
      key_err_q      <= 1'b0;
      key_code_q     <= '0;
      key_is_digit_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= raw_c;
      sync2_q        <= sync1_q;
      sample_q       <= sample_d;
      cnt_q          <= cnt_d;
      key_valid_q    <= key_valid_d;
      key_err_q      <= key_err_d;
      key_code_q     <= key_code_d;
      key_is_digit_q <= key_is_digit_d;
      busy_q         <= busy_d;
    end
  end

  // Press debounce in DEB, release debounce in REL; HELD ignores everything but all-released.
  always_comb begin
    state_d        = state_q;
    sample_d       = sample_q;
    cnt_d          = cnt_q;
    key_valid_d    = 1'b0;
    key_err_d      = 1'b0;
    key_code_d     = key_code_q;
    key_is_digit_d = key_is_digit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (s_c != '0) begin
          sample_d = s_c;
          cnt_d    = '0;
          state_d  = ST_DEB;
        end
      end
      ST_DEB: begin
        if (s_c == '0) begin
          state_d = ST_IDLE;
        end else if (s_c != sample_q) begin
          sample_d = s_c;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          if (one_hot_c) begin
            key_valid_d    = 1'b1;
            key_code_d     = key_idx_c;
            key_is_digit_d = (key_idx_c < CODE_W'(NDIGIT));
          end else begin
            key_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (s_c == '0) begin
          cnt_d   = '0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (s_c != '0) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign kp.key_valid_o    = key_valid_q;
  assign kp.key_err_o      = key_err_q;
  assign kp.key_code_o     = key_code_q;
  assign kp.key_is_digit_o = key_is_digit_q;
  assign kp.busy_o         = busy_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key traffic, checked
// every cycle against a run-length reference model for two debounce settings.
module tb_keypad_scanner;

  localparam int D_A = 16;
  localparam int D_B = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] raw;

  always #5 clk = ~clk;

  keypad_scanner_if kif_a ();
  keypad_scanner_if kif_b ();

  assign kif_a.digit_i = raw[9:0];
  assign kif_a.open_i  = raw[10];
  assign kif_a.close_i = raw[11];
  assign kif_a.set_i   = raw[12];
  assign kif_b.digit_i = raw[9:0];
  assign kif_b.open_i  = raw[10];
  assign kif_b.close_i = raw[11];
  assign kif_b.set_i   = raw[12];

  keypad_scanner #(.DEBOUNCE_CYCLES(D_A)) dut_a (.clk(clk), .rst_n(rst_n), .kp(kif_a));
  keypad_scanner #(.DEBOUNCE_CYCLES(D_B)) dut_b (.clk(clk), .rst_n(rst_n), .kp(kif_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press is accepted once the same non-zero synchronised
  // vector has been seen d+1 times in a row; re-arming needs d+1 zero samples.
  typedef struct {
    logic [12:0] r1;
    logic [12:0] r2;
    logic [12:0] run_val;
    int          run_len;
    int          zero_len;
    bit          armed;
    bit          valid;
    bit          err;
    bit          digit;
    bit          busy;
    logic [3:0]  code;
  } mdl_t;

  mdl_t ma, mb;

  function automatic void mdl_step(inout mdl_t m, input logic [12:0] r, input logic rn, input int d);
    logic [12:0] s;
    if (!rn) begin
      m = '{default: 0};
      m.armed = 1'b1;
      return;
    end
    s    = m.r2;
    m.r2 = m.r1;
    m.r1 = r;
    m.valid = 1'b0;
    m.err   = 1'b0;
    if (m.armed) begin
      if (s == '0) m.run_len = 0;
      else if (m.run_len > 0 && s == m.run_val) m.run_len++;
      else begin
        m.run_val = s;
        m.run_len = 1;
      end
      if (m.run_len == d + 1) begin
        m.armed    = 1'b0;
        m.zero_len = 0;
        if ($countones(s) == 1) begin
          m.valid = 1'b1;
          m.code  = 4'($clog2(s));
          m.digit = (m.code < 4'd10);
        end else begin
          m.err = 1'b1;
        end
      end
    end else begin
      if (s == '0) m.zero_len++;
      else m.zero_len = 0;
      if (m.zero_len == d + 1) begin
        m.armed   = 1'b1;
        m.run_len = 0;
      end
    end
    m.busy = !(m.armed && m.run_len == 0);
  endfunction

  // Per-cycle scoreboard for both instances.
  always @(posedge clk) begin
    mdl_step(ma, raw, rst_n, D_A);
    mdl_step(mb, raw, rst_n, D_B);
    #1;
    check_eq("valid_a", 32'(kif_a.key_valid_o),    32'(ma.valid));
    check_eq("err_a",   32'(kif_a.key_err_o),      32'(ma.err));
    check_eq("code_a",  32'(kif_a.key_code_o),     32'(ma.code));
    check_eq("digit_a", 32'(kif_a.key_is_digit_o), 32'(ma.digit));
    check_eq("busy_a",  32'(kif_a.busy_o),         32'(ma.busy));
    check_eq("valid_b", 32'(kif_b.key_valid_o),    32'(mb.valid));
    check_eq("err_b",   32'(kif_b.key_err_o),      32'(mb.err));
    check_eq("code_b",  32'(kif_b.key_code_o),     32'(mb.code));
    check_eq("digit_b", 32'(kif_b.key_is_digit_o), 32'(mb.digit));
    check_eq("busy_b",  32'(kif_b.busy_o),         32'(mb.busy));
  end

  function automatic logic [12:0] key(input int k);
    return 13'(1) << k;
  endfunction

  task automatic drive(input logic [12:0] v);
    @(negedge clk);
    raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Observe instance A for n edges; first_v is the edge index (0-based) of the first strobe.
  task automatic watch(input int n, output int nv, output int ne, output int first_v);
    nv = 0;
    ne = 0;
    first_v = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (kif_a.key_valid_o) begin
        if (first_v < 0) first_v = i;
        nv++;
      end
      if (kif_a.key_err_o) ne++;
    end
  endtask

  int nv, ne, fv, nv2, ne2, fv2;
  logic [12:0] v;

  initial begin
    raw   = '0;
    rst_n = 1'b0;

    // Reset with keys held: everything stays at zero.
    idle(2);
    raw = 13'b1_0010_0100_0001;
    idle(3);
    check_eq("rst_valid", 32'(kif_a.key_valid_o),    32'd0);
    check_eq("rst_err",   32'(kif_a.key_err_o),      32'd0);
    check_eq("rst_code",  32'(kif_a.key_code_o),     32'd0);
    check_eq("rst_digit", 32'(kif_a.key_is_digit_o), 32'd0);
    check_eq("rst_busy",  32'(kif_a.busy_o),         32'd0);

    // Release reset while I5 is held: treated as a fresh press.
    @(negedge clk);
    raw   = key(5);
    rst_n = 1'b1;
    watch(40, nv, ne, fv);
    check_eq("rst5_count", 32'(nv), 32'd1);
    check_eq("rst5_edge",  32'(fv), 32'(D_A + 2));
    check_eq("rst5_code",  32'(kif_a.key_code_o), 32'd5);
    check_eq("rst5_digit", 32'(kif_a.key_is_digit_o), 32'd1);
    drive('0);
    idle(40);

    // Clean press of I7, held 100 cycles.
    drive(key(7));
    watch(100, nv, ne, fv);
    check_eq("i7_count", 32'(nv), 32'd1);
    check_eq("i7_edge",  32'(fv), 32'(D_A + 2));
    check_eq("i7_code",  32'(kif_a.key_code_o), 32'd7);
    check_eq("i7_digit", 32'(kif_a.key_is_digit_o), 32'd1);
    drive('0);
    idle(40);

    // Press bounce on I3, then hold.
    for (int k = 0; k < 4; k++) begin
      drive((k % 2 == 0) ? key(3) : 13'd0);
      idle(4);
    end
    drive(key(3));
    watch(60, nv, ne, fv);
    check_eq("i3_count", 32'(nv), 32'd1);
    check_eq("i3_edge",  32'(fv), 32'(D_A + 2));
    check_eq("i3_code",  32'(kif_a.key_code_o), 32'd3);
    // Release bounce: no extra event.
    drive('0);
    idle(3);
    drive(key(3));
    idle(3);
    drive('0);
    watch(60, nv, ne, fv);
    check_eq("i3rel_valid", 32'(nv), 32'd0);
    check_eq("i3rel_err",   32'(ne), 32'd0);
    check_eq("i3rel_busy",  32'(kif_a.busy_o), 32'd0);

    // Function keys OPEN, CLOSE, SET.
    for (int k = 10; k <= 12; k++) begin
      drive(key(k));
      watch(40, nv, ne, fv);
      check_eq("fn_count", 32'(nv), 32'd1);
      check_eq("fn_code",  32'(kif_a.key_code_o), 32'(k));
      check_eq("fn_digit", 32'(kif_a.key_is_digit_o), 32'd0);
      drive('0);
      idle(40);
    end

    // Multi-key press I1+I2: error, code unchanged; then I2 alone.
    drive(key(1) | key(2));
    watch(50, nv, ne, fv);
    check_eq("multi_err",   32'(ne), 32'd1);
    check_eq("multi_valid", 32'(nv), 32'd0);
    check_eq("multi_code",  32'(kif_a.key_code_o), 32'd12);
    drive('0);
    idle(40);
    drive(key(2));
    watch(40, nv, ne, fv);
    check_eq("i2_count", 32'(nv), 32'd1);
    check_eq("i2_code",  32'(kif_a.key_code_o), 32'd2);
    drive('0);
    idle(40);

    // Short glitch on I9: no event of any kind.
    drive(key(9));
    watch(10, nv, ne, fv);
    drive('0);
    watch(60, nv2, ne2, fv2);
    check_eq("glitch_valid", 32'(nv + nv2), 32'd0);
    check_eq("glitch_err",   32'(ne + ne2), 32'd0);
    check_eq("glitch_busy",  32'(kif_a.busy_o), 32'd0);

    // Random traffic with occasional asynchronous resets.
    for (int seg = 0; seg < 400; seg++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 99));
      if (r < 12) v = '0;
      else if (r < 27) v = key(int'($urandom_range(0, 12))) | key(int'($urandom_range(0, 12)));
      else v = key(int'($urandom_range(0, 12)));
      len = int'($urandom_range(1, 45));
      if ($urandom_range(0, 99) < 2) begin
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      drive(v);
      idle(len - 1);
    end
    drive('0);
    idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
